// File: rtl/mcu_merge_sched.sv
// MCU-ordered block scheduler: drains Y_PER_MCU Y blocks, then one Cb and one Cr
// block per MCU from FWFT FIFOs, emitting a registered, channel-tagged word stream.
module mcu_merge_sched #(
  parameter int Y_PER_MCU = 4
) (
  input  logic        clk,
  input  logic        img_rst,
  input  logic        start,
  input  logic [15:0] mcu_total,
  input  logic        y_empty,
  input  logic        cb_empty,
  input  logic        cr_empty,
  input  logic [32:0] y_rd_data,
  input  logic [32:0] cb_rd_data,
  input  logic [32:0] cr_rd_data,
  output logic        y_read_req,
  output logic        cb_read_req,
  output logic        cr_read_req,
  output logic [31:0] jpeg_bitstream,
  output logic [1:0]  data_valid,
  output logic        mcu_done,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RD_Y, RD_CB, RD_CR} state_t;

  localparam logic [1:0] Y_LAST = 2'(Y_PER_MCU - 1);

  state_t      state, state_nxt;
  logic [1:0]  y_cnt, y_cnt_nxt;
  logic [15:0] mcu_cnt, mcu_cnt_nxt;
  logic [15:0] mcu_tot, mcu_tot_nxt;
  logic        pop;
  logic [31:0] pop_word;
  logic [1:0]  pop_tag;
  logic        mcu_end;
  logic        frame_end;

  always_comb begin
    state_nxt   = state;
    y_cnt_nxt   = y_cnt;
    mcu_cnt_nxt = mcu_cnt;
    mcu_tot_nxt = mcu_tot;
    y_read_req  = 1'b0;
    cb_read_req = 1'b0;
    cr_read_req = 1'b0;
    pop_word    = '0;
    pop_tag     = '0;
    mcu_end     = 1'b0;
    frame_end   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (mcu_total == 16'd0) begin
            frame_end = 1'b1;
          end else begin
            mcu_tot_nxt = mcu_total;
            y_cnt_nxt   = '0;
            mcu_cnt_nxt = '0;
            state_nxt   = RD_Y;
          end
        end
      end
      RD_Y: begin
        y_read_req = !y_empty;
        pop_word   = y_rd_data[31:0];
        pop_tag    = 2'd1;
        if (y_read_req && y_rd_data[32]) begin
          if (y_cnt == Y_LAST) begin
            y_cnt_nxt = '0;
            state_nxt = RD_CB;
          end else begin
            y_cnt_nxt = y_cnt + 2'd1;
          end
        end
      end
      RD_CB: begin
        cb_read_req = !cb_empty;
        pop_word    = cb_rd_data[31:0];
        pop_tag     = 2'd2;
        if (cb_read_req && cb_rd_data[32]) state_nxt = RD_CR;
      end
      RD_CR: begin
        cr_read_req = !cr_empty;
        pop_word    = cr_rd_data[31:0];
        pop_tag     = 2'd3;
        if (cr_read_req && cr_rd_data[32]) begin
          mcu_cnt_nxt = mcu_cnt + 16'd1;
          mcu_end     = 1'b1;
          // 17-bit compare so mcu_tot = 65535 never needs a wrapped counter
          if (({1'b0, mcu_cnt} + 17'd1) == {1'b0, mcu_tot}) begin
            frame_end = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RD_Y;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // No pops while reset is held, so no FIFO word is lost across the reset edge
    if (img_rst) begin
      y_read_req  = 1'b0;
      cb_read_req = 1'b0;
      cr_read_req = 1'b0;
    end
    pop = y_read_req | cb_read_req | cr_read_req;
  end

  always_ff @(posedge clk) begin
    if (img_rst) begin
      state          <= IDLE;
      y_cnt          <= '0;
      mcu_cnt        <= '0;
      mcu_tot        <= '0;
      jpeg_bitstream <= '0;
      data_valid     <= '0;
      mcu_done       <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      y_cnt      <= y_cnt_nxt;
      mcu_cnt    <= mcu_cnt_nxt;
      mcu_tot    <= mcu_tot_nxt;
      data_valid <= pop ? pop_tag : 2'd0;
      if (pop) jpeg_bitstream <= pop_word;
      mcu_done   <= mcu_end;
      frame_done <= frame_end;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/mcu_merge_sched.md
# mcu_merge_sched

MCU-ordered read scheduler for the three channel FIFOs (Y, Cb, Cr) that sit between the per-channel entropy coders and the bitstream output. It replaces free-running rotation with data-driven sequencing: Y_PER_MCU complete Y blocks, then one Cb block, then one Cr block per MCU, repeated for a programmed MCU count. It pops whole blocks, delimited by a last-word flag, and emits a tagged 32-bit word stream with the same channel coding on `data_valid` as the merge output (1 = Y, 2 = Cb, 3 = Cr).

## Interface
Parameters:
- Y_PER_MCU, 4, Y blocks per MCU (1 = 4:4:4, 2 = 4:2:2, 4 = 4:2:0); legal range 1–4.

Ports (the FIFOs are first-word-fall-through: `x_rd_data` is valid whenever `x_empty` = 0):
- clk  in  1  system clock; all logic on rising edge.
- img_rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- mcu_total  in  16  MCUs in the frame; latched on an accepted `start`.
- y_empty, cb_empty, cr_empty  in  1 each  channel FIFO empty flags.
- y_rd_data, cb_rd_data, cr_rd_data  in  33 each  FIFO head; [31:0] is the word, [32] marks the last word of an 8x8 block.
- y_read_req, cb_read_req, cr_read_req  out  1 each  pop strobe, combinational; at most one asserted per cycle.
- jpeg_bitstream  out  32  registered output word.
- data_valid  out  2  registered channel tag; 0 = no word.
- mcu_done  out  1  one-cycle pulse on the cycle the last Cr word of an MCU is output.
- frame_done  out  1  one-cycle pulse at end of frame.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, RD_Y, RD_CB, RD_CR.
- Counters: `y_cnt` (2 bits, 0..Y_PER_MCU-1) and `mcu_cnt` (16 bits). Latched register `mcu_tot`.
- IDLE:
  - On `start` with `mcu_total` != 0: latch `mcu_tot`, clear both counters, go to RD_Y.
  - On `start` with `mcu_total` = 0: stay in IDLE and pulse `frame_done` next cycle; no reads.
- RD_Y: `y_read_req = !y_empty`. On a pop with bit 32 set:
  - If `y_cnt` = Y_PER_MCU-1: clear `y_cnt`, go to RD_CB.
  - Otherwise increment `y_cnt`.
- RD_CB: `cb_read_req = !cb_empty`. A pop with bit 32 set goes to RD_CR.
- RD_CR: `cr_read_req = !cr_empty`. A pop with bit 32 set:
  - Increments `mcu_cnt` and flags `mcu_done`.
  - If `mcu_cnt` + 1 = `mcu_tot`: go to IDLE and flag `frame_done`. Otherwise go to RD_Y.
- The scheduler never reads out of order. An empty FIFO for the current channel stalls the scheduler (no pop, `data_valid` = 0), even if other FIFOs hold data.
- `start` while busy is ignored; `mcu_total` changes after latch have no effect.
- Single-word block (bit 32 set on the first word) is legal; state advances after one cycle.
- Pop with bit 32 clear: counters and state unchanged.

## Timing
- Throughput: one word per cycle while the current FIFO is non-empty; no bubble at block or channel boundaries.
- Latency: a word popped in cycle N appears on `jpeg_bitstream`/`data_valid` in cycle N+1.
- `mcu_done` and `frame_done` are registered and coincide with `data_valid` = 3 for the closing Cr word. `frame_done` for `mcu_total` = 0 is the cycle after `start`.
- `busy` falls in the same cycle `frame_done` rises. A new `start` is accepted in that cycle.
- When no pop occurs in cycle N, cycle N+1 has `data_valid` = 0 and `jpeg_bitstream` holds its previous value.
- Reset values: `jpeg_bitstream` = 0, `data_valid` = 0, `mcu_done` = 0, `frame_done` = 0, `busy` = 0; read requests 0; state IDLE; counters 0.
- `img_rst` mid-frame: the next cycle is IDLE with all outputs at reset values; no partial-MCU completion pulses. FIFO flushing is the FIFOs' responsibility.
- `mcu_cnt` never wraps; `mcu_total` = 65535 is legal.

## Test plan
- 4:2:0, `mcu_total` = 2, all FIFOs pre-loaded with blocks of 3 words (last flag on word 3) -> output tags 1x12, 2x3, 3x3, repeated twice; 36 consecutive valid cycles; `mcu_done` on outputs 18 and 36; `frame_done` on output 36 only.
- Y_PER_MCU = 1, Cb FIFO empty for 5 cycles after Y block completes -> 5 cycles of `data_valid` = 0, no Cr pops despite Cr data present, then Cb words resume in order.
- `start` with `mcu_total` = 0 -> `frame_done` pulse next cycle, `busy` never high, no read requests.
- Single-word blocks, `mcu_total` = 1, Y_PER_MCU = 4 -> exactly 6 output words tagged 1,1,1,1,2,3; `frame_done` with the sixth word.
- `img_rst` asserted during RD_CB -> next cycle all outputs 0 and state IDLE; a subsequent `start` restarts at RD_Y with `y_cnt` = 0.
- Second `start` pulse mid-frame with a different `mcu_total` -> ignored; frame ends after the originally latched count.
